// File: rtl/pwm_audio_out.sv
// pwm_audio_out
//   Final audio stage: buffers PCM samples in a small FIFO and plays one
//   sample per PWM period. The sample value is the PWM duty (number of high
//   cycles per 2**WIDTH-cycle period). On underrun the last duty is held so
//   the pin never glitches.
//
// Ports
//   clk           system clock
//   nrst          asynchronous active-low reset
//   en            block enable; low = synchronous flush + silence
//   sample_in     unsigned PCM sample (duty value)
//   sample_valid  sample_in valid
//   sample_ready  FIFO can accept a sample this cycle
//   pwm_out       registered PWM audio bit
//   underrun      1-cycle pulse: period boundary reached with FIFO empty
//   fifo_count    number of buffered samples, 0..DEPTH
module pwm_audio_out #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     pwm_out,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [WIDTH-1:0] sample_t;

    sample_t         mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    sample_t         cnt_q, cnt_d;
    sample_t         duty_q, duty_d;
    logic            pwm_q, pwm_d;
    logic            underrun_q, underrun_d;

    logic boundary;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign boundary   = (cnt_q == '1);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

    // Ready depends only on registered state: a pop on this edge never frees
    // a slot for a push on the same edge.
    assign sample_ready = en && !fifo_full;
    assign push         = sample_valid && sample_ready;
    // Popping uses the pre-edge count, so a sample pushed into an empty FIFO
    // cannot be consumed on the same edge.
    assign pop          = en && boundary && !fifo_empty;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        pwm_d      = pwm_q;
        underrun_d = 1'b0;

        if (!en) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            cnt_d    = '0;
            duty_d   = '0;
            pwm_d    = 1'b0;
        end else begin
            cnt_d      = cnt_q + WIDTH'(1);
            pwm_d      = (cnt_q < duty_q);
            underrun_d = boundary && fifo_empty;

            if (pop) begin
                duty_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    // NOTE: the sample storage is deliberately not reset; entries are only
    // read after being written, tracked by count_q, so reset is unnecessary.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign pwm_out    = pwm_q;
    assign underrun   = underrun_q;
    assign fifo_count = count_q;

endmodule
